// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin MMIO arbiter with bounded bus lock,
// address decode and one-cycle-late read data return steering.
module mmio_bus_arbiter #(
    parameter logic [31:0] BRAM_BASE = 32'h0000_0000,
    parameter logic [31:0] BRAM_TOP  = 32'h0000_07FF,
    parameter logic [31:0] GPIO_BASE = 32'hFFFF_FFF0,
    parameter logic [31:0] GPIO_TOP  = 32'hFFFF_FFF3,
    parameter logic [31:0] UART_BASE = 32'hFFFF_FFF4,
    parameter logic [31:0] UART_TOP  = 32'hFFFF_FFF7,
    parameter int          MAX_LOCK  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_lock,
    input  logic        m1_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [3:0]  m0_byteMask,
    input  logic [3:0]  m1_byteMask,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic [3:0]  byteMask,
    input  logic [31:0] bramReadData,
    input  logic [31:0] gpioReadData,
    input  logic [31:0] uartReadData,
    output logic        bus_err
);

    localparam int CW = $clog2(MAX_LOCK) + 1;

    typedef enum logic [1:0] {R_NONE, R_BRAM, R_GPIO, R_UART} region_t;
    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t        state, state_nxt;
    logic          lock_owner, lock_owner_nxt;
    logic [CW-1:0] lock_cnt, lock_cnt_nxt;
    logic          last_gnt, last_gnt_nxt;
    logic          rsp_valid, rsp_master;
    region_t       rsp_region, region;
    logic          any_gnt, winner;
    logic          owner_req, owner_lock;
    logic [31:0]   sel_addr, rsp_data;
    logic          sel_we;

    // Unsigned window test written as an offset compare so a zero base folds cleanly.
    function automatic logic in_range(input logic [31:0] a,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a - lo) <= (hi - lo);
    endfunction

    always_comb begin
        state_nxt      = state;
        lock_owner_nxt = lock_owner;
        lock_cnt_nxt   = lock_cnt;
        last_gnt_nxt   = last_gnt;
        any_gnt        = 1'b0;
        winner         = 1'b0;
        owner_req      = lock_owner ? m1_req  : m0_req;
        owner_lock     = lock_owner ? m1_lock : m0_lock;
        if (state == LOCKED && owner_req) begin
            any_gnt      = 1'b1;
            winner       = lock_owner;
            last_gnt_nxt = lock_owner;
            if (!owner_lock || lock_cnt >= CW'(MAX_LOCK - 1)) begin
                state_nxt    = UNLOCKED;
                lock_cnt_nxt = '0;
            end else begin
                lock_cnt_nxt = lock_cnt + 1'b1;
            end
        end else begin
            // A lock owner that drops its request releases the bus this cycle.
            state_nxt    = UNLOCKED;
            lock_cnt_nxt = '0;
            if (m0_req && m1_req) begin
                any_gnt = 1'b1;
                winner  = ~last_gnt;
            end else if (m0_req || m1_req) begin
                any_gnt = 1'b1;
                winner  = m1_req;
            end
            if (any_gnt) begin
                last_gnt_nxt = winner;
                if (winner ? m1_lock : m0_lock) begin
                    state_nxt      = LOCKED;
                    lock_owner_nxt = winner;
                    lock_cnt_nxt   = CW'(1);
                end
            end
        end
        if (reset) begin
            any_gnt = 1'b0;
        end
    end

    always_comb begin
        sel_addr = winner ? m1_addr : m0_addr;
        sel_we   = winner ? m1_we   : m0_we;
        unique case (1'b1)
            in_range(sel_addr, BRAM_BASE, BRAM_TOP): region = R_BRAM;
            in_range(sel_addr, GPIO_BASE, GPIO_TOP): region = R_GPIO;
            in_range(sel_addr, UART_BASE, UART_TOP): region = R_UART;
            default:                                 region = R_NONE;
        endcase
    end

    assign m0_gnt       = any_gnt && !winner;
    assign m1_gnt       = any_gnt && winner;
    assign memAddress   = any_gnt ? sel_addr : '0;
    assign memWriteData = any_gnt ? (winner ? m1_wdata : m0_wdata) : '0;
    assign byteMask     = any_gnt ? (winner ? m1_byteMask : m0_byteMask) : '0;
    assign memWrite     = any_gnt && sel_we && (region != R_NONE);

    always_comb begin
        unique case (rsp_region)
            R_BRAM:  rsp_data = bramReadData;
            R_GPIO:  rsp_data = gpioReadData;
            R_UART:  rsp_data = uartReadData;
            default: rsp_data = '0;
        endcase
        m0_rvalid = rsp_valid && !rsp_master;
        m1_rvalid = rsp_valid && rsp_master;
        m0_rdata  = m0_rvalid ? rsp_data : '0;
        m1_rdata  = m1_rvalid ? rsp_data : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= UNLOCKED;
            lock_owner <= 1'b0;
            lock_cnt   <= '0;
            last_gnt   <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_master <= 1'b0;
            rsp_region <= R_NONE;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            lock_owner <= lock_owner_nxt;
            lock_cnt   <= lock_cnt_nxt;
            last_gnt   <= last_gnt_nxt;
            rsp_valid  <= any_gnt && !sel_we;
            rsp_master <= winner;
            rsp_region <= region;
            bus_err    <= bus_err | (any_gnt && region == R_NONE);
        end
    end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter; read returns are
// tracked through an expected-response queue, one entry per cycle.
module tb_mmio_bus_arbiter;

    localparam logic [31:0] BRAM_D = 32'hDEAD_BEEF;
    localparam logic [31:0] GPIO_D = 32'h1234_5678;
    localparam logic [31:0] UART_D = 32'hCAFE_0055;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_lock, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_we, m1_we;
    logic [3:0]  m0_byteMask, m1_byteMask;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] memAddress, memWriteData;
    logic        memWrite;
    logic [3:0]  byteMask;
    logic [31:0] bramReadData, gpioReadData, uartReadData;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v;
        logic        m;
        logic [31:0] d;
    } rsp_t;

    rsp_t sb[$];

    always #5 clk = ~clk;

    mmio_bus_arbiter #(.MAX_LOCK(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_we(m0_we), .m1_we(m1_we),
        .m0_byteMask(m0_byteMask), .m1_byteMask(m1_byteMask),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memWrite(memWrite), .byteMask(byteMask),
        .bramReadData(bramReadData), .gpioReadData(gpioReadData),
        .uartReadData(uartReadData), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_reset();
        rsp_t n;
        sb.delete();
        n.v = 1'b0;
        n.m = 1'b0;
        n.d = '0;
        sb.push_back(n);
    endtask

    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic settle(input logic g0, input logic g1,
                          input logic [31:0] d);
        rsp_t e, n;
        #4;
        chk("m0_gnt", 32'(m0_gnt), 32'(g0));
        chk("m1_gnt", 32'(m1_gnt), 32'(g1));
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $error("FAIL sb_underflow: observed empty expected entry");
            e.v = 1'b0;
            e.m = 1'b0;
            e.d = '0;
        end else begin
            e = sb.pop_front();
        end
        chk("m0_rvalid", 32'(m0_rvalid), 32'(e.v && !e.m));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(e.v && e.m));
        chk("m0_rdata", m0_rdata, (e.v && !e.m) ? e.d : 32'h0);
        chk("m1_rdata", m1_rdata, (e.v && e.m) ? e.d : 32'h0);
        n.v = (g0 && !m0_we) || (g1 && !m1_we);
        n.m = g1;
        n.d = d;
        sb.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bramReadData = BRAM_D;
        gpioReadData = GPIO_D;
        uartReadData = UART_D;
        reset = 1'b1;
        m0_req = 1'b1;  m1_req = 1'b1;
        m0_lock = 1'b0; m1_lock = 1'b0;
        m0_addr = 32'h20; m1_addr = 32'hFFFF_FFF4;
        m0_wdata = 32'h0; m1_wdata = 32'h0;
        m0_we = 1'b0;   m1_we = 1'b0;
        m0_byteMask = 4'hF; m1_byteMask = 4'hF;

        #12;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        chk("rst_addr", memAddress, 32'h0);
        chk("rst_wdata", memWriteData, 32'h0);
        chk("rst_we", 32'(memWrite), 32'h0);
        chk("rst_mask", 32'(byteMask), 32'h0);
        chk("rst_err", 32'(bus_err), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_reset();

        // Round robin from reset: m0 first.
        settle(1, 0, BRAM_D); tick();
        settle(0, 1, UART_D); tick();
        settle(1, 0, BRAM_D); tick();
        settle(0, 1, UART_D); tick();
        m0_req = 1'b0; m1_req = 1'b0;
        settle(0, 0, 0); tick();

        // Single master read.
        m0_req = 1'b1; m0_addr = 32'h10;
        settle(1, 0, BRAM_D);
        chk("single_addr", memAddress, 32'h10);
        chk("single_we", 32'(memWrite), 32'h0);
        tick();
        m0_req = 1'b0;
        settle(0, 0, 0);
        chk("idle_addr", memAddress, 32'h0);
        tick();

        // Lock: m1 holds the bus for 4 beats.
        m0_req = 1'b1; m0_addr = 32'h40;
        m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h100;
        settle(0, 1, BRAM_D); tick();
        settle(0, 1, BRAM_D); tick();
        settle(0, 1, BRAM_D); tick();
        m1_lock = 1'b0;
        settle(0, 1, BRAM_D); tick();
        m1_req = 1'b0;
        settle(1, 0, BRAM_D); tick();

        // Lock timeout with m1_lock held.
        m1_req = 1'b1; m1_lock = 1'b1;
        settle(0, 1, BRAM_D); tick();
        settle(0, 1, BRAM_D); tick();
        settle(0, 1, BRAM_D); tick();
        settle(0, 1, BRAM_D); tick();
        settle(1, 0, BRAM_D); tick();
        settle(0, 1, BRAM_D); tick();
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        settle(0, 0, 0); tick();

        // Region steering and error flag.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'hFFFF_FFF0;
        m0_wdata = 32'hAA; m0_byteMask = 4'b0001;
        settle(1, 0, 0);
        chk("gpio_we", 32'(memWrite), 32'h1);
        chk("gpio_mask", 32'(byteMask), 32'h1);
        chk("gpio_wdata", memWriteData, 32'hAA);
        chk("err_clear", 32'(bus_err), 32'h0);
        tick();
        m0_we = 1'b0; m0_addr = 32'hFFFF_FFF4; m0_byteMask = 4'hF;
        settle(1, 0, UART_D); tick();
        m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'hFFFF_FFF2;
        settle(0, 1, GPIO_D); tick();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0001_0000;
        settle(1, 0, 0);
        chk("unmapped_we", 32'(memWrite), 32'h0);
        chk("err_before", 32'(bus_err), 32'h0);
        tick();
        m0_we = 1'b0; m0_addr = 32'h8000_0000;
        settle(1, 0, 0);
        chk("err_set", 32'(bus_err), 32'h1);
        tick();
        m0_req = 1'b0;
        settle(0, 0, 0);
        chk("err_sticky", 32'(bus_err), 32'h1);
        tick();
        settle(0, 0, 0);
        chk("err_sticky2", 32'(bus_err), 32'h1);
        tick();

        // Reset between a granted read and its return.
        m0_req = 1'b1; m0_addr = 32'h10;
        settle(1, 0, BRAM_D);
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(m0_gnt), 32'h0);
        chk("mid_rst_err", 32'(bus_err), 32'h0);
        m0_req = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'h0);
        chk("mid_rst_addr", memAddress, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_reset();
        m0_req = 1'b1; m1_req = 1'b1;
        m1_addr = 32'hFFFF_FFF4;
        settle(1, 0, BRAM_D); tick();
        settle(0, 1, UART_D); tick();
        m0_req = 1'b0; m1_req = 1'b0;
        settle(0, 0, 0); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_bus_arbiter.md
Name: mmio_bus_arbiter

Overview:
- Shares the single SoC MMIO bus (BRAM, GPIO, UART slaves) between two requesters: m0 (CPU) and m1 (UART boot loader / DMA engine).
- Round-robin arbitration with optional bus lock for multi-beat sequences; lock length is bounded.
- Registers the granted master and decoded region for the one-cycle-late synchronous read return.
- Steers slave read data back to the correct master with a valid strobe.

Parameters:
- BRAM_BASE, 32'h0000_0000, lowest BRAM address.
- BRAM_TOP, 32'h0000_07FF, highest BRAM address.
- GPIO_BASE, 32'hFFFF_FFF0, lowest GPIO address.
- GPIO_TOP, 32'hFFFF_FFF3, highest GPIO address.
- UART_BASE, 32'hFFFF_FFF4, lowest UART address.
- UART_TOP, 32'hFFFF_FFF7, highest UART address.
- MAX_LOCK, 16, maximum consecutive granted cycles under lock before forced release (≥2).

Ports:
- clk  in  1  bus clock (slowed SoC clock).
- reset  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1  access request, held until granted.
- m0_lock, m1_lock  in  1  keep grant after this beat.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_byteMask, m1_byteMask  in  4  byte lane enables.
- m0_gnt, m1_gnt  out  1  combinational grant; the beat is accepted this cycle.
- m0_rdata, m1_rdata  out  32  read return data.
- m0_rvalid, m1_rvalid  out  1  read data valid, one cycle after the granted read.
- memAddress  out  32  to slaves.
- memWriteData  out  32  to slaves.
- memWrite  out  1  to slaves.
- byteMask  out  4  to slaves.
- bramReadData, gpioReadData, uartReadData  in  32  slave read data, valid the cycle after the address.
- bus_err  out  1  sticky flag: an access hit an unmapped address.

Behaviour:
- Reset values (async, immediate): last_gnt = 1 (so m0 wins the first tie), locked = 0, lock_cnt = 0, rsp_master/rsp_region/rsp_valid = 0, bus_err = 0.
- Reset values of outputs: gnt = 0, rvalid = 0, rdata = 0, memWrite = 0, memAddress = 0, memWriteData = 0, byteMask = 0.
- State machine, UNLOCKED:
  - Only one request: grant it.
  - Both request: grant the master that is not last_gnt.
  - No request: idle. Slave outputs go to 0, memWrite = 0.
  - On a grant: last_gnt <= winner.
  - If the winner's lock = 1: go to LOCKED(winner) and set lock_cnt = 1.
- State machine, LOCKED(m):
  - m is granted whenever m_req = 1; the other master is blocked.
  - lock_cnt increments on each granted beat.
  - Leave to UNLOCKED when any of these holds: m_lock = 0 on a granted beat; m_req = 0; lock_cnt reaches MAX_LOCK.
  - On a forced release at MAX_LOCK, the other master has priority next cycle if it is requesting.
  - Re-lock is allowed only through normal arbitration.
- Slave bus is a combinational mux of the granted master's addr/wdata/byteMask.
- Address decode (inclusive ranges, unsigned compare): region is one of BRAM, GPIO, UART, NONE.
- memWrite = granted && we && region != NONE. Writes to unmapped addresses are dropped and set bus_err.
- Read return pipeline:
  - On a granted read, register rsp_valid = 1 along with rsp_master and rsp_region.
  - Next cycle, the selected master sees rvalid = 1 and rdata = the data of the matching slave region.
  - For region NONE, rdata = 0, rvalid = 1, and bus_err is set.
  - The non-selected master sees rdata = 0 and rvalid = 0.
- Writes produce no rvalid.
- Back-to-back beats every cycle are supported, including alternating masters: the response for a beat in cycle N always appears in N+1 alongside the new beat's address.
- bus_err is cleared only by reset.
- Reset mid-operation: any in-flight response is discarded (no rvalid), the lock is dropped, and arbitration restarts with m0 priority.

Test Plan:
- Single master: m0 reads 0x0000_0010 with bramReadData = 0xDEADBEEF → m0_gnt = 1 in cycle N; m0_rvalid = 1 and m0_rdata = 0xDEADBEEF in N+1; m1_rvalid = 0.
- Round robin: both req continuously, no lock → grants alternate m0, m1, m0, m1 starting with m0 after reset. Each rvalid is routed to the correct master one cycle later.
- Lock: m1_lock = 1 for 4 beats while m0_req = 1 → m1 gets 4 consecutive grants; m0 is granted on the next cycle.
- Lock timeout: MAX_LOCK = 4, m1_lock held high, m0 requesting → m1 gets 4 grants, then m0 is granted for 1 beat, then arbitration resumes.
- Region steer and error:
  - m0 writes 0x0000_00AA to 0xFFFF_FFF0 with mask 4'b0001 → memWrite = 1, byteMask = 4'b0001.
  - Read of 0xFFFF_FFF4 returns uartReadData.
  - Write to 0x0001_0000 → memWrite = 0, bus_err = 1 and stays set.
  - Read of 0x8000_0000 → rdata = 0, rvalid = 1.
- Reset mid-read: reset asserted between a granted read and its return → no rvalid. After release: all outputs 0, m0 wins the first tie.
